// File: rtl/seq_detect_scheduler_pkg.sv
// Shared definitions for the serial pattern-detect scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_detect_scheduler_pkg;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Pattern matched by default; oldest bit sits in bit 2
    localparam logic [2:0] PATTERN_DEFAULT = 3'b110;

    // Requester ids
    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/seq_detect_scheduler_pattern_window.sv
// 3-bit sliding window over a serial bit stream; flags a match against PATTERN.
// Latency: hit is combinational on the bit being shifted in this cycle.
// Backpressure: none; en qualifies each bit, clr restarts the window.
//
// Ports: clk/rst (async active-high), clr (sync clear of history and fill),
//        en (bit_in valid this cycle), bit_in (serial bit), hit (window match).
module pattern_window
    import seq_detect_scheduler_pkg::*;
#(
    parameter logic [2:0] PATTERN = PATTERN_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic bit_in,
    output logic hit
);

    logic [1:0] history;
    // Counts bits seen since the last clear, saturating at 2; a match is only
    // trusted once two real bits sit in history, so cleared zeros never hit.
    logic [1:0] fill;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            history <= 2'b00;
            fill    <= 2'd0;
        end else if (clr) begin
            history <= 2'b00;
            fill    <= 2'd0;
        end else if (en) begin
            history <= {history[0], bit_in};
            if (fill != 2'd2) begin
                fill <= fill + 2'd1;
            end
        end
    end

    always_comb begin
        hit = en && (fill == 2'd2) && ({history, bit_in} == PATTERN);
    end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin shares one serial "110" detector between two word requesters.
// Latency: accept at T, bits on T+1..T+W, done pulse at T+W+1; one word per W+2 cycles.
// Backpressure: ready only in IDLE for the granted requester; both stall otherwise.
//
// Ports: clk, rst (async active-high)
//        reqN_valid/reqN_data/reqN_ready : word handshake per requester
//        ser_bit/ser_valid               : bit fed to the detector (SHIFT)
//        busy                            : word in progress (SHIFT or DONE)
//        done/done_id/done_count/done_hit: result; id/count/hit hold until next done
module seq_detect_scheduler
    import seq_detect_scheduler_pkg::*;
#(
    parameter int         W       = 8,
    parameter logic [2:0] PATTERN = PATTERN_DEFAULT,
    parameter int         CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_data,
    output logic             req1_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [CNT_W-1:0] done_count,
    output logic             done_hit
);

    localparam int            BW       = (W > 2) ? $clog2(W) : 2;
    localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

    state_t             state, state_nxt;
    logic               prio;
    logic [W-1:0]       shreg;
    logic [BW-1:0]      bitcnt;
    logic [CNT_W-1:0]   match_cnt, match_nxt;
    logic               cur_id;

    logic               grant_id;
    logic               any_valid;
    logic               accept;
    logic               win_hit;
    logic               last_bit;

    // Grant: a lone requester always wins; on a tie the pointer decides.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_id = prio;
        end else if (req1_valid) begin
            grant_id = REQ1;
        end else begin
            grant_id = REQ0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        ser_valid  = 1'b0;
        ser_bit    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        last_bit   = (bitcnt == LAST_BIT);
        case (state)
            IDLE: begin
                if (any_valid) begin
                    accept     = 1'b1;
                    req0_ready = (grant_id == REQ0);
                    req1_ready = (grant_id == REQ1);
                    state_nxt  = SHIFT;
                end
            end
            SHIFT: begin
                ser_valid = 1'b1;
                ser_bit   = shreg[W-1];
                busy      = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    pattern_window #(
        .PATTERN (PATTERN)
    ) u_window (
        .clk    (clk),
        .rst    (rst),
        .clr    (accept),
        .en     (ser_valid),
        .bit_in (ser_bit),
        .hit    (win_hit)
    );

    // Saturating hit count including the bit being shifted this cycle
    always_comb begin
        match_nxt = match_cnt;
        if (win_hit && (match_cnt != {CNT_W{1'b1}})) begin
            match_nxt = match_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio       <= REQ0;
            shreg      <= '0;
            bitcnt     <= '0;
            match_cnt  <= '0;
            cur_id     <= REQ0;
            done_id    <= 1'b0;
            done_count <= '0;
            done_hit   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg     <= grant_id ? req1_data : req0_data;
                        cur_id    <= grant_id;
                        bitcnt    <= '0;
                        match_cnt <= '0;
                    end
                end
                SHIFT: begin
                    shreg     <= {shreg[W-2:0], 1'b0};
                    bitcnt    <= bitcnt + BW'(1);
                    match_cnt <= match_nxt;
                    // Result registers load on the final bit so they are
                    // already valid during the DONE cycle.
                    if (last_bit) begin
                        done_id    <= cur_id;
                        done_count <= match_nxt;
                        done_hit   <= (match_nxt != '0);
                    end
                end
                DONE: begin
                    // The requester just served loses the next tie.
                    prio <= ~done_id;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
module tb_seq_detect_scheduler;

    localparam int W     = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;

    // Main instance (PATTERN 110)
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic [W-1:0]     req0_data = '0, req1_data = '0;
    logic             req0_ready, req1_ready;
    logic             ser_bit, ser_valid, busy, done, done_id, done_hit;
    logic [CNT_W-1:0] done_count;

    // Second instance (PATTERN 000)
    logic             b0_valid = 1'b0;
    logic [W-1:0]     b0_data = '0;
    logic             b0_ready, b1_ready;
    logic             b_ser_bit, b_ser_valid, b_busy, b_done, b_done_id, b_done_hit;
    logic [CNT_W-1:0] b_done_count;
    logic             b1_valid = 1'b0;
    logic [W-1:0]     b1_data = '0;

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    logic m_prio = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_detect_scheduler #(.W(W), .PATTERN(3'b110), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .ser_bit(ser_bit), .ser_valid(ser_valid), .busy(busy), .done(done),
        .done_id(done_id), .done_count(done_count), .done_hit(done_hit)
    );

    seq_detect_scheduler #(.W(W), .PATTERN(3'b000), .CNT_W(CNT_W)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(b0_valid), .req0_data(b0_data), .req0_ready(b0_ready),
        .req1_valid(b1_valid), .req1_data(b1_data), .req1_ready(b1_ready),
        .ser_bit(b_ser_bit), .ser_valid(b_ser_valid), .busy(b_busy), .done(b_done),
        .done_id(b_done_id), .done_count(b_done_count), .done_hit(b_done_hit)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: count pattern occurrences in the MSB-first bit stream of w,
    // windows ending at serial position 2 or later, saturating at CNT_W bits.
    function automatic int model_hits(input logic [W-1:0] w, input logic [2:0] pat);
        int n = 0;
        logic [W-1:0] v = w;
        for (int i = 2; i < W; i++) begin
            if ({v[W+1-i], v[W-i], v[W-1-i]} == pat) n++;
        end
        if (n > (1 << CNT_W) - 1) n = (1 << CNT_W) - 1;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #4;
        rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ser_valid", ser_valid, 0);
        check("rst_ser_bit", ser_bit, 0);
        check("rst_done_id", done_id, 0);
        check("rst_done_count", done_count, 0);
        check("rst_done_hit", done_hit, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        b0_valid   = 1'b0;
        m_prio     = 1'b0;
        tick();
        check("rst_hold_done", done, 0);
        rst = 1'b0;
    endtask

    // Serve one word: wait for a grant, check it, the serial stream and the result.
    task automatic run_word(input bit keep_valid, output int hs_cyc);
        logic         exp_id;
        logic [W-1:0] word;
        int           exp_cnt;
        int           k;
        #1;
        hs_cyc = -1;
        for (k = 0; k < 30 && !(req0_ready || req1_ready); k++) tick();
        if (!(req0_ready || req1_ready)) begin
            check("grant_timeout", 0, 1);
            return;
        end
        exp_id  = (req0_valid && req1_valid) ? m_prio : req1_valid;
        word    = exp_id ? req1_data : req0_data;
        exp_cnt = model_hits(word, 3'b110);
        check("grant", {req1_ready, req0_ready}, exp_id ? 2 : 1);
        hs_cyc = cyc;
        tick();
        if (!keep_valid) begin
            if (exp_id) req1_valid = 1'b0;
            else        req0_valid = 1'b0;
        end
        #1;
        check("ready_in_shift", {req1_ready, req0_ready}, 0);
        for (int i = 0; i < W; i++) begin
            check("ser_valid", ser_valid, 1);
            check("ser_bit", ser_bit, word[W-1-i]);
            check("busy_shift", busy, 1);
            check("no_early_done", done, 0);
            tick();
        end
        check("done", done, 1);
        check("done_busy", busy, 1);
        check("done_id", done_id, exp_id);
        check("done_count", done_count, exp_cnt);
        check("done_hit", done_hit, exp_cnt != 0);
        m_prio = ~exp_id;
        tick();
        check("done_pulse_end", done, 0);
        check("done_id_hold", done_id, exp_id);
        check("done_count_hold", done_count, exp_cnt);
    endtask

    initial begin
        int hs, hs_prev, k;
        rst = 1'b1;
        tick();
        do_reset();

        // Ready right after release
        req0_valid = 1'b1;
        req0_data  = 8'b11011000;
        #1;
        check("rdy_after_rst", req0_ready, 1);
        run_word(0, hs);

        // Tie after reset: req0 first, then req1 in the next IDLE cycle
        do_reset();
        req0_valid = 1'b1; req0_data = 8'hFF;
        req1_valid = 1'b1; req1_data = 8'h66;
        run_word(0, hs);
        hs_prev = hs;
        run_word(0, hs);
        check("tie_b2b_period", hs - hs_prev, W + 2);

        // req1 held continuously: back-to-back every W+2 cycles
        req1_valid = 1'b1; req1_data = 8'b00000110;
        run_word(1, hs_prev);
        for (int n = 0; n < 2; n++) begin
            run_word(1, hs);
            check("b2b_period", hs - hs_prev, W + 2);
            hs_prev = hs;
        end
        req1_valid = 1'b0;

        // Leave prio at 1, then reset in the 5th shift cycle
        req0_valid = 1'b1; req0_data = W'($urandom);
        run_word(0, hs);
        req0_valid = 1'b1; req0_data = 8'hDB;
        #1;
        for (k = 0; k < 30 && !req0_ready; k++) tick();
        check("mid_rst_grant", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        repeat (4) tick();
        check("mid_rst_in_shift", ser_valid, 1);
        do_reset();
        check("mid_rst_busy", busy, 0);
        // prio back at 0: req0 wins the tie
        req0_valid = 1'b1; req0_data = 8'hDB;
        req1_valid = 1'b1; req1_data = W'($urandom);
        run_word(0, hs);
        run_word(0, hs);

        // Randomized traffic against the model
        for (int n = 0; n < 40; n++) begin
            if (!req0_valid && !req1_valid && ($urandom % 3 == 0)) begin
                repeat ($urandom_range(1, 3)) tick();
                check("idle_no_busy", busy, 0);
            end
            if (!req0_valid && ($urandom % 2 == 1)) begin
                req0_valid = 1'b1; req0_data = W'($urandom);
            end
            if (!req1_valid && ($urandom % 2 == 1)) begin
                req1_valid = 1'b1; req1_data = W'($urandom);
            end
            if (!req0_valid && !req1_valid) begin
                req0_valid = 1'b1; req0_data = W'($urandom);
            end
            run_word(0, hs);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // PATTERN=000 instance: overlap counting and fill rule
        b0_valid = 1'b1; b0_data = 8'h00;
        #1;
        for (k = 0; k < 30 && !b0_ready; k++) tick();
        check("b_grant", b0_ready, 1);
        tick();
        b0_valid = 1'b0;
        repeat (W) tick();
        check("b_done", b_done, 1);
        check("b_done_count", b_done_count, model_hits(8'h00, 3'b000));
        check("b_done_count_abs", b_done_count, 6);
        check("b_done_hit", b_done_hit, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
